// File: rtl/mvu_ctrl.sv
// mvu_ctrl: sequences bit-serial matrix-vector ops for one MVU job.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, busy, done      job request / in progress / completion pulse
//   cfg_*                  job configuration, latched on accepted start
//   mul_mode, acc_*, max_* registered MVU datapath controls
//   rdw_addr               weight-bank read address
//   rdd_en/grnt/addr       data-bank read request, grant, address
//   wrd_en/grnt/addr       data-bank write request, grant, address
module mvu_ctrl #(
  parameter int BWBANKA = 9,
  parameter int BDBANKA = 14,
  parameter int DRAIN   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [2:0]         cfg_wprec,
  input  logic [2:0]         cfg_iprec,
  input  logic [5:0]         cfg_ntiles,
  input  logic [1:0]         cfg_mul_mode,
  input  logic               cfg_pool,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_dbase,
  input  logic [BDBANKA-1:0] cfg_obase,
  output logic [1:0]         mul_mode,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               max_en,
  output logic               max_clr,
  output logic               max_pool,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr
);

  // Drain counter must hold DRAIN-1; DRAIN is expected to be at least 1.
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         wp_q, wp_d;
  logic [2:0]         ip_q, ip_d;
  logic [5:0]         nt_q, nt_d;
  logic [1:0]         mode_q, mode_d;
  logic               pool_q, pool_d;
  logic [BWBANKA-1:0] wbase_q, wbase_d;
  logic [BDBANKA-1:0] dbase_q, dbase_d;
  logic [BDBANKA-1:0] obase_q, obase_d;

  // Indices of the op currently presented on the read port.
  logic [3:0]    s_q, s_d;
  logic [2:0]    w_q, w_d;
  logic [5:0]    t_q, t_d;
  logic          first_q, first_d;
  logic          sh_q, sh_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [3:0] wlo;
  logic [3:0] sm1;
  logic [2:0] whi;
  logic       last;

  always_comb begin
    wlo  = (s_q > 4'(ip_q)) ? s_q - 4'(ip_q) : 4'd0;
    sm1  = s_q - 4'd1;
    whi  = (sm1 > 4'(wp_q)) ? wp_q : sm1[2:0];
    // s=0 has a single weight bit, so only the tile index matters.
    last = (s_q == 4'd0) && (t_q == nt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      ip_q    <= '0;
      nt_q    <= '0;
      mode_q  <= '0;
      pool_q  <= 1'b0;
      wbase_q <= '0;
      dbase_q <= '0;
      obase_q <= '0;
      s_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      first_q <= 1'b0;
      sh_q    <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      ip_q    <= ip_d;
      nt_q    <= nt_d;
      mode_q  <= mode_d;
      pool_q  <= pool_d;
      wbase_q <= wbase_d;
      dbase_q <= dbase_d;
      obase_q <= obase_d;
      s_q     <= s_d;
      w_q     <= w_d;
      t_q     <= t_d;
      first_q <= first_d;
      sh_q    <= sh_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    ip_d    = ip_q;
    nt_d    = nt_q;
    mode_d  = mode_q;
    pool_d  = pool_q;
    wbase_d = wbase_q;
    dbase_d = dbase_q;
    obase_d = obase_q;
    s_d     = s_q;
    w_d     = w_q;
    t_d     = t_q;
    first_d = first_q;
    sh_d    = sh_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          wp_d    = cfg_wprec;
          ip_d    = cfg_iprec;
          nt_d    = cfg_ntiles;
          mode_d  = cfg_mul_mode;
          pool_d  = cfg_pool;
          wbase_d = cfg_wbase;
          dbase_d = cfg_dbase;
          obase_d = cfg_obase;
          s_d     = 4'(cfg_wprec) + 4'(cfg_iprec);
          w_d     = cfg_wprec;
          t_d     = '0;
          first_d = 1'b1;
          sh_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (rdd_grnt) begin
          first_d = 1'b0;
          sh_d    = 1'b0;
          if (last) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else if (t_q != nt_q) begin
            t_d = t_q + 6'd1;
          end else if (4'(w_q) > wlo) begin
            t_d = '0;
            w_d = w_q - 3'd1;
          end else begin
            t_d  = '0;
            s_d  = sm1;
            w_d  = whi;
            sh_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(DRAIN - 1)) state_d = S_WRITE;
        else dcnt_d = dcnt_q + 1'b1;
      end
      S_WRITE: begin
        if (wrd_grnt) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic               busy_d, done_d, issue;
  logic               acc_clr_d, acc_sh_d, max_en_d, max_clr_d;
  logic               max_pool_d, rdd_en_d, wrd_en_d;
  logic [1:0]         mul_mode_d;
  logic [3:0]         i_d;
  logic [15:0]        woff, doff;
  logic [BWBANKA-1:0] rdw_d;
  logic [BDBANKA-1:0] rdd_d, wrd_d;

  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    issue      = (state_d == S_ISSUE);
    i_d        = s_d - 4'(w_d);
    woff       = 16'(t_d) * (16'(wp_d) + 16'd1) + 16'(w_d);
    doff       = 16'(t_d) * (16'(ip_d) + 16'd1) + 16'(i_d);
    rdd_en_d   = issue;
    rdw_d      = issue ? wbase_d + BWBANKA'(woff) : '0;
    rdd_d      = issue ? dbase_d + BDBANKA'(doff) : '0;
    acc_clr_d  = issue & first_d;
    acc_sh_d   = issue & sh_d;
    max_clr_d  = issue & first_d & pool_d;
    max_en_d   = (state_d == S_DRAIN) && (dcnt_d == DW'(DRAIN - 1)) && pool_d;
    wrd_en_d   = (state_d == S_WRITE);
    wrd_d      = wrd_en_d ? obase_d : '0;
    mul_mode_d = busy_d ? mode_d : 2'd0;
    max_pool_d = busy_d & pool_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_clr  <= 1'b0;
      acc_sh   <= 1'b0;
      max_en   <= 1'b0;
      max_clr  <= 1'b0;
      max_pool <= 1'b0;
      mul_mode <= '0;
      rdd_en   <= 1'b0;
      rdw_addr <= '0;
      rdd_addr <= '0;
      wrd_en   <= 1'b0;
      wrd_addr <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      acc_clr  <= acc_clr_d;
      acc_sh   <= acc_sh_d;
      max_en   <= max_en_d;
      max_clr  <= max_clr_d;
      max_pool <= max_pool_d;
      mul_mode <= mul_mode_d;
      rdd_en   <= rdd_en_d;
      rdw_addr <= rdw_d;
      rdd_addr <= rdd_d;
      wrd_en   <= wrd_en_d;
      wrd_addr <= wrd_d;
    end
  end

endmodule

// File: tb/tb_mvu_ctrl.sv
// tb_mvu_ctrl: randomized self-checking bench for mvu_ctrl.
// Expected op stream is built from nested loops over (s, w, t).
module tb_mvu_ctrl;
  localparam int BW = 9;
  localparam int BD = 14;
  localparam int DR = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done;
  logic [2:0]    cfg_wprec, cfg_iprec;
  logic [5:0]    cfg_ntiles;
  logic [1:0]    cfg_mul_mode;
  logic          cfg_pool;
  logic [BW-1:0] cfg_wbase;
  logic [BD-1:0] cfg_dbase, cfg_obase;
  logic [1:0]    mul_mode;
  logic          acc_clr, acc_sh, max_en, max_clr, max_pool;
  logic [BW-1:0] rdw_addr;
  logic          rdd_en, rdd_grnt, wrd_en, wrd_grnt;
  logic [BD-1:0] rdd_addr, wrd_addr;

  mvu_ctrl #(.BWBANKA(BW), .BDBANKA(BD), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_wprec(cfg_wprec), .cfg_iprec(cfg_iprec),
    .cfg_ntiles(cfg_ntiles), .cfg_mul_mode(cfg_mul_mode),
    .cfg_pool(cfg_pool), .cfg_wbase(cfg_wbase),
    .cfg_dbase(cfg_dbase), .cfg_obase(cfg_obase),
    .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh),
    .max_en(max_en), .max_clr(max_clr), .max_pool(max_pool),
    .rdw_addr(rdw_addr), .rdd_en(rdd_en), .rdd_grnt(rdd_grnt),
    .rdd_addr(rdd_addr), .wrd_en(wrd_en), .wrd_grnt(wrd_grnt),
    .wrd_addr(wrd_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int wa;
    int da;
    bit clr;
    bit sh;
    bit mclr;
  } op_t;

  op_t q[$];

  function automatic logic [63:0] outs();
    return 64'({busy, done, acc_clr, acc_sh, max_en, max_clr, max_pool,
                rdd_en, wrd_en, mul_mode, rdw_addr, rdd_addr, wrd_addr});
  endfunction

  task automatic build(input int wp, ip, nt, pool, wb, db);
    int WP, IP, T, top, hi, lo;
    op_t o;
    WP = wp + 1;
    IP = ip + 1;
    T = nt + 1;
    top = WP + IP - 2;
    q.delete();
    for (int s = top; s >= 0; s--) begin
      hi = (s < WP - 1) ? s : WP - 1;
      lo = (s - IP + 1 > 0) ? s - IP + 1 : 0;
      for (int w = hi; w >= lo; w--)
        for (int t = 0; t < T; t++) begin
          o.wa = (wb + t * WP + w) % (1 << BW);
          o.da = (db + t * IP + (s - w)) % (1 << BD);
          o.clr = (q.size() == 0);
          o.sh = (t == 0) && (w == hi) && (s != top);
          o.mclr = o.clr && (pool != 0);
          q.push_back(o);
        end
    end
  endtask

  task automatic run_job(input int wp, ip, nt, mode, pool, wb, db, ob,
                         input int rprob, stall_idx, stall_len, wdelay,
                         input bit scr, input int rst_at);
    int cyc, lc, wr_cyc, first_cyc, wr_first, n_ops, popped;
    int stalled, wwait, n_max;
    bit fin, g, wg;
    build(wp, ip, nt, pool, wb, db);
    n_ops = q.size();
    @(negedge clk);
    cfg_wprec = 3'(wp);
    cfg_iprec = 3'(ip);
    cfg_ntiles = 6'(nt);
    cfg_mul_mode = 2'(mode);
    cfg_pool = pool[0];
    cfg_wbase = BW'(wb);
    cfg_dbase = BD'(db);
    cfg_obase = BD'(ob);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    lc = -100;
    wr_cyc = -100;
    first_cyc = -1;
    wr_first = -1;
    popped = 0;
    stalled = 0;
    wwait = 0;
    n_max = 0;
    fin = 0;
    while (!fin && cyc < 20000) begin
      if (rst_at >= 0 && rdd_en && popped == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle", outs(), 64'd0);
        q.delete();
        return;
      end
      if (busy) begin
        check("mul_mode", 64'(mul_mode), 64'(mode));
        check("max_pool", 64'(max_pool), 64'(pool));
      end
      if (rdd_en) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check("first_op_cyc", 64'(cyc), 64'd1);
        end
        if (q.size() == 0) begin
          check("extra_op", 64'd1, 64'd0);
        end else begin
          check("rdw_addr", 64'(rdw_addr), 64'(q[0].wa));
          check("rdd_addr", 64'(rdd_addr), 64'(q[0].da));
          check("acc_clr", 64'(acc_clr), 64'(q[0].clr));
          check("acc_sh", 64'(acc_sh), 64'(q[0].sh));
          check("max_clr", 64'(max_clr), 64'(q[0].mclr));
        end
      end
      g = ($urandom_range(99) < rprob);
      if (rdd_en && popped == stall_idx && stalled < stall_len) begin
        g = 0;
        stalled++;
      end
      if (rdd_en && g && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
        lc = cyc;
      end
      if (max_en) begin
        n_max++;
        check("max_en_cyc", 64'(cyc), 64'(lc + DR));
      end
      wg = 0;
      if (wrd_en) begin
        if (wr_first < 0) begin
          wr_first = cyc;
          check("drain_len", 64'(cyc - lc), 64'(DR + 1));
        end
        check("wrd_addr", 64'(wrd_addr), 64'(ob));
        wg = (wwait >= wdelay);
        wwait++;
        if (wg) wr_cyc = cyc;
      end
      if (done) begin
        check("done_cyc", 64'(cyc), 64'(wr_cyc + 1));
        fin = 1;
      end
      rdd_grnt = g;
      wrd_grnt = wg;
      if (scr && busy && !fin) begin
        start = 1'($urandom_range(1));
        cfg_wprec = 3'($urandom);
        cfg_iprec = 3'($urandom);
        cfg_ntiles = 6'($urandom);
        cfg_mul_mode = 2'($urandom);
        cfg_pool = 1'($urandom);
        cfg_wbase = BW'($urandom);
        cfg_dbase = BD'($urandom);
        cfg_obase = BD'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) begin
      check("timeout", 64'd0, 64'd1);
    end else begin
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_mode", 64'(mul_mode), 64'd0);
      check("op_count", 64'(popped), 64'(n_ops));
      check("max_en_cnt", 64'(n_max), 64'(pool));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rdd_grnt = 1'b0;
    wrd_grnt = 1'b0;
    cfg_wprec = '0;
    cfg_iprec = '0;
    cfg_ntiles = '0;
    cfg_mul_mode = '0;
    cfg_pool = 1'b0;
    cfg_wbase = '0;
    cfg_dbase = '0;
    cfg_obase = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", outs(), 64'd0);

    // smallest job, grants always given
    run_job(0, 0, 0, 1, 1, 0, 0, 0, 100, -1, 0, 0, 0, -1);
    // 2x2 precision, one tile
    run_job(1, 1, 0, 2, 0, 0, 0, 0, 100, -1, 0, 0, 0, -1);
    // read grant withheld for 5 cycles on op 2
    run_job(1, 2, 1, 3, 1, 7, 33, 5, 100, 1, 5, 0, 0, -1);
    // weight address wraparound
    run_job(0, 0, 3, 0, 0, 510, 100, 9, 100, -1, 0, 0, 0, -1);
    // reset during op 3, then a full job
    run_job(2, 2, 1, 1, 1, 3, 4, 5, 100, -1, 0, 0, 0, 2);
    run_job(2, 1, 2, 1, 1, 3, 4, 5, 70, -1, 0, 0, 0, -1);
    // start/cfg noise while busy, delayed write grant
    run_job(1, 1, 1, 2, 1, 20, 40, 1234, 100, -1, 0, 4, 1, -1);

    // start together with reset is dropped
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("start_in_rst", outs(), 64'd0);
    @(negedge clk);
    check("start_in_rst2", 64'(busy), 64'd0);

    for (int k = 0; k < 15; k++)
      run_job($urandom_range(7), $urandom_range(7), $urandom_range(7),
              $urandom_range(3), $urandom_range(1), $urandom_range(511),
              $urandom_range(16383), $urandom_range(16383),
              $urandom_range(100, 30), -1, 0, $urandom_range(3),
              1'($urandom_range(1)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
